// File: rtl/sys_bus_bridge_if.sv
// CPU-side data-memory bus between the core and sys_bus_bridge.
// The CPU drives the master end and the bridge answers on the slave end.
interface sys_bus_bridge_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_rd;

  modport master (output cpu_addr, output cpu_wd, output cpu_byteen, input cpu_rd);
  modport slave  (input cpu_addr, input cpu_wd, input cpu_byteen, output cpu_rd);
endinterface

// File: rtl/sys_bus_bridge.sv
// Address decoder and read-return path between the CPU and DM/timer/UART/tube/switch/LED.
// Optional macro BRIDGE_DT_SCAN_EN builds the multiplexed digital-tube scanner.
module sys_bus_bridge #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter int          SW_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  sys_bus_bridge_if.slave         cpu,
  input  logic                    resp_uart_int,
  output logic [5:0]              hw_int,
  output logic [31:0]             dm_addr,
  output logic [31:0]             dm_wd,
  output logic [3:0]              dm_byteen,
  input  logic [31:0]             dm_rd,
  output logic [31:0]             tc_addr,
  output logic                    tc_we,
  output logic [31:0]             tc_wd,
  input  logic [31:0]             tc_rd,
  input  logic                    tc_irq,
  output logic [31:0]             uart_addr,
  output logic                    uart_we,
  output logic [31:0]             uart_wd,
  input  logic [31:0]             uart_rd,
  input  logic                    uart_rx_irq,
  input  logic [SW_WORDS*32-1:0]  sw_in,
  output logic [31:0]             led,
  output logic [7:0]              dt_seg,
  output logic [7:0]              dt_sel
);

  localparam logic [2:0] RegNone = 3'd0;
  localparam logic [2:0] RegDm   = 3'd1;
  localparam logic [2:0] RegTc   = 3'd2;
  localparam logic [2:0] RegUart = 3'd3;
  localparam logic [2:0] RegDt   = 3'd4;
  localparam logic [2:0] RegSw   = 3'd5;
  localparam logic [2:0] RegLed  = 3'd6;

  localparam logic [31:0] SwBase = 32'h0000_7F60;
  localparam logic [31:0] SwLast = SwBase + 32'(4 * SW_WORDS - 1);

  logic [31:0]             addr;
  logic [2:0]              region;
  logic [2:0]              selQ;
  logic [31:0]             rdQ;
  logic [31:0]             rdNext;
  logic [31:0]             swOffset;
  logic [31:0]             dt0;
  logic [31:0]             dt1;
  logic                    uartPend;
  logic [SW_WORDS*32-1:0]  swSync1;
  logic [SW_WORDS*32-1:0]  swSync2;

  assign addr = cpu.cpu_addr;

  always_comb begin
    region = RegNone;
    if (addr <= 32'h0000_2FFF)
      region = RegDm;
    else if (addr >= 32'h0000_7F00 && addr <= 32'h0000_7F0B)
      region = RegTc;
    else if (addr >= 32'h0000_7F30 && addr <= 32'h0000_7F3F)
      region = RegUart;
    else if (addr >= 32'h0000_7F50 && addr <= 32'h0000_7F57)
      region = RegDt;
    else if (addr >= SwBase && addr <= SwLast)
      region = RegSw;
    else if (addr >= 32'h0000_7F70 && addr <= 32'h0000_7F73)
      region = RegLed;
  end

  assign dm_addr   = addr;
  assign tc_addr   = addr;
  assign uart_addr = addr;
  assign dm_wd     = cpu.cpu_wd;
  assign tc_wd     = cpu.cpu_wd;
  assign uart_wd   = cpu.cpu_wd;
  assign dm_byteen = (region == RegDm) ? cpu.cpu_byteen : 4'b0000;
  assign tc_we     = (region == RegTc) && (|cpu.cpu_byteen);
  assign uart_we   = (region == RegUart) && (|cpu.cpu_byteen);

  // Peripheral word for the current access; captured so it lines up with the DM's one-cycle read.
  assign swOffset = (addr - SwBase) >> 2;

  always_comb begin
    rdNext = 32'h0;
    case (region)
      RegTc:   rdNext = tc_rd;
      RegUart: rdNext = uart_rd;
      RegDt:   rdNext = addr[2] ? dt1 : dt0;
      RegLed:  rdNext = led;
      RegSw: begin
        for (int i = 0; i < SW_WORDS; i++) begin
          if (swOffset == 32'(i))
            rdNext = swSync2[i*32 +: 32];
        end
      end
      default: rdNext = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      selQ <= RegNone;
      rdQ  <= 32'h0;
    end else begin
      selQ <= region;
      rdQ  <= rdNext;
    end
  end

  assign cpu.cpu_rd = (selQ == RegDm)   ? dm_rd :
                      (selQ == RegNone) ? 32'h0 : rdQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      led <= 32'h0;
      dt0 <= 32'h0;
      dt1 <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (cpu.cpu_byteen[b]) begin
          if (region == RegLed)
            led[b*8 +: 8] <= cpu.cpu_wd[b*8 +: 8];
          if (region == RegDt && !addr[2])
            dt0[b*8 +: 8] <= cpu.cpu_wd[b*8 +: 8];
          if (region == RegDt && addr[2])
            dt1[b*8 +: 8] <= cpu.cpu_wd[b*8 +: 8];
        end
      end
    end
  end

  // Switch inputs are asynchronous, so reads only ever see the second synchronizer stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      swSync1 <= '0;
      swSync2 <= '0;
    end else begin
      swSync1 <= sw_in;
      swSync2 <= swSync1;
    end
  end

  // A new receive pulse takes priority over an acknowledge landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)
      uartPend <= 1'b0;
    else if (uart_rx_irq)
      uartPend <= 1'b1;
    else if (resp_uart_int)
      uartPend <= 1'b0;
  end

  assign hw_int = {3'b000, 1'b0, uartPend, tc_irq};

`ifdef BRIDGE_DT_SCAN_EN
  logic [15:0] scanCnt;
  logic [2:0]  digitIdx;
  logic [3:0]  nibble;
  logic [7:0]  segCode;

  always_ff @(posedge clk) begin
    if (reset) begin
      scanCnt  <= 16'd0;
      digitIdx <= 3'd0;
    end else if (scanCnt == SCAN_DIV - 16'd1) begin
      scanCnt  <= 16'd0;
      digitIdx <= digitIdx + 3'd1;
    end else begin
      scanCnt <= scanCnt + 16'd1;
    end
  end

  assign nibble = dt0[{digitIdx, 2'b00} +: 4];

  always_comb begin
    segCode = 8'hFF;
    case (nibble)
      4'h0: segCode = 8'hC0;
      4'h1: segCode = 8'hF9;
      4'h2: segCode = 8'hA4;
      4'h3: segCode = 8'hB0;
      4'h4: segCode = 8'h99;
      4'h5: segCode = 8'h92;
      4'h6: segCode = 8'h82;
      4'h7: segCode = 8'hF8;
      4'h8: segCode = 8'h80;
      4'h9: segCode = 8'h90;
      4'hA: segCode = 8'h88;
      4'hB: segCode = 8'h83;
      4'hC: segCode = 8'hC6;
      4'hD: segCode = 8'hA1;
      4'hE: segCode = 8'h86;
      4'hF: segCode = 8'h8E;
      default: segCode = 8'hFF;
    endcase
  end

  assign dt_sel = ~(8'd1 << digitIdx);
  assign dt_seg = {~dt1[digitIdx], segCode[6:0]};
`else
  logic unusedScanDiv;

  assign unusedScanDiv = ^SCAN_DIV;
  assign dt_sel = 8'hFF;
  assign dt_seg = 8'hFF;
`endif

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Randomized self-checking bench for sys_bus_bridge against a region-level reference model.
// Honours BRIDGE_DT_SCAN_EN when the DUT is built with the tube scanner.
module tb_sys_bus_bridge;

  localparam int RNone = 0;
  localparam int RDm   = 1;
  localparam int RTc   = 2;
  localparam int RUart = 3;
  localparam int RDt   = 4;
  localparam int RSw   = 5;
  localparam int RLed  = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         resp_uart_int;
  logic [5:0]   hw_int;
  logic [31:0]  dm_addr, dm_wd, dm_rd;
  logic [3:0]   dm_byteen;
  logic [31:0]  tc_addr, tc_wd, tc_rd;
  logic         tc_we, tc_irq;
  logic [31:0]  uart_addr, uart_wd, uart_rd;
  logic         uart_we, uart_rx_irq;
  logic [127:0] sw_in;
  logic [31:0]  led;
  logic [7:0]   dt_seg, dt_sel;

  sys_bus_bridge_if bus ();

  sys_bus_bridge #(.SCAN_DIV(16'd2), .SW_WORDS(4)) dut (
    .clk(clk), .reset(reset), .cpu(bus),
    .resp_uart_int(resp_uart_int), .hw_int(hw_int),
    .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_byteen(dm_byteen), .dm_rd(dm_rd),
    .tc_addr(tc_addr), .tc_we(tc_we), .tc_wd(tc_wd), .tc_rd(tc_rd), .tc_irq(tc_irq),
    .uart_addr(uart_addr), .uart_we(uart_we), .uart_wd(uart_wd), .uart_rd(uart_rd),
    .uart_rx_irq(uart_rx_irq), .sw_in(sw_in), .led(led), .dt_seg(dt_seg), .dt_sel(dt_sel)
  );

  always #5 clk = ~clk;

  int compareCount = 0;
  int mismatchCount = 0;

  // Stimulus knobs consumed by the next applyStimulus call
  logic         rxReq, respReq, rstReq, tcIrqVal;
  logic [31:0]  tcVal, uartVal, dmVal;
  logic [127:0] swVal;

  // Reference model state
  logic [31:0]  ledM, dt0M, dt1M, prevVal;
  logic         pendM;
  int           prevRegion;
  logic [127:0] sw0, sw1, sw2;
  int           scanCntM, idxM;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic int regionOf(input logic [31:0] a);
    if (a <= 32'h2FFF) return RDm;
    if (a >= 32'h7F00 && a <= 32'h7F0B) return RTc;
    if (a >= 32'h7F30 && a <= 32'h7F3F) return RUart;
    if (a >= 32'h7F50 && a <= 32'h7F57) return RDt;
    if (a >= 32'h7F60 && a <= 32'h7F6F) return RSw;
    if (a >= 32'h7F70 && a <= 32'h7F73) return RLed;
    return RNone;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] hexSeg(input logic [3:0] n);
    logic [7:0] table16 [16];
    table16 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return table16[n];
  endfunction

  task automatic resetModel();
    ledM = 0; dt0M = 0; dt1M = 0; pendM = 0;
    prevRegion = RNone; prevVal = 0;
    sw0 = '0; sw1 = '0;
    scanCntM = 0; idxM = 0;
  endtask

  // One bus cycle: drive at the falling edge, check 1ns later, then advance the model across the rising edge
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    int          region, swIdx;
    logic [31:0] rdExp, readVal;
    logic [7:0]  segExp;
    @(negedge clk);
    sw2 = sw1; sw1 = sw0; sw0 = swVal;
    bus.cpu_addr = addr; bus.cpu_wd = wd; bus.cpu_byteen = be;
    reset = rstReq; uart_rx_irq = rxReq; resp_uart_int = respReq;
    tc_rd = tcVal; uart_rd = uartVal; dm_rd = dmVal; tc_irq = tcIrqVal; sw_in = swVal;
    #1;
    region = regionOf(addr);
    rdExp = (prevRegion == RDm) ? dmVal : (prevRegion == RNone) ? 32'h0 : prevVal;
    checkOutput("cpu_rd", bus.cpu_rd, rdExp);
    checkOutput("dm_byteen", {28'h0, dm_byteen}, (region == RDm) ? {28'h0, be} : 32'h0);
    checkOutput("tc_we", {31'h0, tc_we}, {31'h0, (region == RTc) && (be != 4'h0)});
    checkOutput("uart_we", {31'h0, uart_we}, {31'h0, (region == RUart) && (be != 4'h0)});
    checkOutput("addr_pass", dm_addr ^ tc_addr ^ uart_addr, addr);
    checkOutput("wd_pass", dm_wd ^ tc_wd ^ uart_wd, wd);
    checkOutput("led", led, ledM);
    checkOutput("hw_int", {26'h0, hw_int}, {30'h0, pendM, tcIrqVal});
`ifdef BRIDGE_DT_SCAN_EN
    segExp = hexSeg(dt0M[idxM*4 +: 4]);
    checkOutput("dt_sel", {24'h0, dt_sel}, {24'h0, ~(8'd1 << idxM)});
    checkOutput("dt_seg", {24'h0, dt_seg}, {24'h0, ~dt1M[idxM], segExp[6:0]});
`else
    segExp = 8'hFF;
    checkOutput("dt_sel", {24'h0, dt_sel}, 32'h0000_00FF);
    checkOutput("dt_seg", {24'h0, dt_seg}, {24'h0, segExp});
`endif
    if (rstReq) begin
      resetModel();
    end else begin
      readVal = 32'h0;
      case (region)
        RTc:   readVal = tcVal;
        RUart: readVal = uartVal;
        RDt:   readVal = addr[2] ? dt1M : dt0M;
        RLed:  readVal = ledM;
        RSw: begin
          swIdx = int'((addr - 32'h7F60) >> 2);
          readVal = sw2[swIdx*32 +: 32];
        end
        default: readVal = 32'h0;
      endcase
      prevRegion = region;
      prevVal = readVal;
      if (region == RLed) ledM = mergeBytes(ledM, wd, be);
      if (region == RDt && !addr[2]) dt0M = mergeBytes(dt0M, wd, be);
      if (region == RDt && addr[2]) dt1M = mergeBytes(dt1M, wd, be);
      if (rxReq) pendM = 1'b1;
      else if (respReq) pendM = 1'b0;
      scanCntM++;
      if (scanCntM == 2) begin
        scanCntM = 0;
        idxM = (idxM + 1) % 8;
      end
    end
    rxReq = 0; respReq = 0; rstReq = 0;
  endtask

  function automatic logic [31:0] randomAddr();
    logic [31:0] edges [6];
    edges = '{32'h0000_2FFC, 32'h0000_3000, 32'h0000_7F0C, 32'h0000_7F74, 32'h0000_9000, 32'h0000_7F40};
    case ($urandom_range(0, 6))
      0: return {18'h0, 14'($urandom_range(0, 32'h2FFC)) & 14'h3FFC};
      1: return 32'h7F00 + 32'(4 * $urandom_range(0, 2));
      2: return 32'h7F30 + 32'(4 * $urandom_range(0, 3));
      3: return 32'h7F50 + 32'(4 * $urandom_range(0, 1));
      4: return 32'h7F60 + 32'(4 * $urandom_range(0, 3));
      5: return 32'h7F70;
      default: return edges[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    reset = 1'b1; uart_rx_irq = 0; resp_uart_int = 0; tc_irq = 0;
    tc_rd = 0; uart_rd = 0; dm_rd = 0; sw_in = '0;
    bus.cpu_addr = 32'h9000; bus.cpu_wd = 0; bus.cpu_byteen = 0;
    rxReq = 0; respReq = 0; rstReq = 0; tcIrqVal = 0;
    tcVal = 0; uartVal = 0; dmVal = 0; swVal = '0;
    sw2 = '0;
    resetModel();
    repeat (2) @(posedge clk);

    // DM write then read
    applyStimulus(32'h10, 32'h1234_5678, 4'hF);
    applyStimulus(32'h10, 32'h0, 4'h0);
    dmVal = 32'h1234_5678;
    applyStimulus(32'h9000, 32'h0, 4'h0);
    dmVal = 0;

    // Partial LED write and readback
    applyStimulus(32'h7F70, 32'hAABB_CCDD, 4'b0011);
    applyStimulus(32'h7F70, 32'h0, 4'h0);
    applyStimulus(32'h9000, 32'h0, 4'h0);

    // Back-to-back TC, DM, NONE reads
    tcVal = 32'd5;
    applyStimulus(32'h7F04, 32'h0, 4'h0);
    applyStimulus(32'h0, 32'h0, 4'h0);
    dmVal = 32'd9;
    applyStimulus(32'h9000, 32'h0, 4'h0);
    dmVal = 0;
    applyStimulus(32'h9000, 32'h0, 4'h0);

    // UART pending latch: set, set-and-clear together, clear
    rxReq = 1; applyStimulus(32'h9000, 0, 0);
    applyStimulus(32'h9000, 0, 0);
    rxReq = 1; respReq = 1; applyStimulus(32'h9000, 0, 0);
    applyStimulus(32'h9000, 0, 0);
    respReq = 1; applyStimulus(32'h9000, 0, 0);
    applyStimulus(32'h9000, 0, 0);

    // Switch change reaches reads only after two synchronizer stages
    swVal[31:0] = 32'hF0F0_0000;
    for (int i = 0; i < 4; i++) applyStimulus(32'h7F60, 0, 0);

    // Tube digits, then reset in the middle of a pending read
    applyStimulus(32'h7F50, 32'h0000_0021, 4'hF);
    for (int i = 0; i < 18; i++) applyStimulus(32'h9000, 0, 0);
    applyStimulus(32'h7F70, 0, 0);
    rstReq = 1; applyStimulus(32'h7F70, 0, 0);
    applyStimulus(32'h9000, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tcVal = $urandom; uartVal = $urandom; dmVal = $urandom;
      tcIrqVal = 1'($urandom_range(0, 1));
      rxReq = ($urandom_range(0, 7) == 0);
      respReq = ($urandom_range(0, 5) == 0);
      rstReq = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 7) == 0) swVal = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(randomAddr(), $urandom, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
